// File: rtl/tx_arb_ctrl_module.sv
// UART transmit frame sequencer with a two-requester round-robin arbiter.
// Grants one producer, latches its byte and shifts a full frame onto txd.
module tx_arb_ctrl_module #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  input  logic       tx_bps_clk,
  output logic       tx_count_sig,
  output logic       txd,
  output logic       busy,
  output logic       grant_id,
  output logic       done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;

  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic PAR_INV   = (PARITY_ODD != 0);
  localparam logic PAR_ON    = (PARITY_EN != 0);

  logic [2:0] state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       last_q, last_d;
  logic       gid_q, gid_d;
  logic       busy_q, busy_d;
  logic       cnt_q, cnt_d;
  logic       txd_q, txd_d;
  logic       done_q, done_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       gnt0, gnt1;

  // On a tie the requester that did not win last time goes first.
  assign gnt0 = req0 & (~req1 | last_q);
  assign gnt1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    last_d     = last_q;
    gid_d      = gid_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt0 | gnt1) begin
          shreg_d = gnt1 ? data1 : data0;
          ack0_d  = gnt0;
          ack1_d  = gnt1;
          gid_d   = gnt1;
          last_d  = gnt1;
          busy_d  = 1'b1;
          cnt_d   = 1'b1;
          txd_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_bps_clk) begin
          txd_d     = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_bps_clk) begin
          if (bit_cnt_q == 4'd8) begin
            if (PAR_ON) begin
              txd_d   = ^shreg_q ^ PAR_INV;
              state_d = S_PAR;
            end else begin
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            txd_d     = shreg_q[bit_cnt_q[2:0]];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (tx_bps_clk) begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_bps_clk) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'd0;
      bit_cnt_q  <= 4'd0;
      stop_cnt_q <= 1'b0;
      last_q     <= 1'b1;
      gid_q      <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      last_q     <= last_d;
      gid_q      <= gid_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign tx_count_sig = cnt_q;
  assign txd          = txd_q;
  assign busy         = busy_q;
  assign grant_id     = gid_q;
  assign done         = done_q;

endmodule

// File: doc/tx_arb_ctrl_module.md
# tx_arb_ctrl_module

Frame sequencer and two-requester round-robin arbiter for the UART transmit path. It grants one of two byte producers, latches that producer's byte, and holds `tx_count_sig` high so the baud generator (`tx_bps_module`) runs. It then shifts a complete UART frame out on `txd`, advancing one bit per `tx_bps_clk` pulse. It sits between the application-side producers and the pin-level TX line.

## Interface
Parameters:
- `PARITY_EN`, 0: 1 inserts a parity bit after data bit 7.
- `PARITY_ODD`, 0: with `PARITY_EN`, 0 selects even parity and 1 selects odd parity.
- `STOP_BITS`, 1: number of stop bits, legal values 1 or 2.

Ports:
- `clk`  in  1  system clock; the block uses only this clock.
- `rst`  in  1  reset, synchronous and active-high.
- `req0`, `req1`  in  1  level requests; each is held until the matching ack.
- `data0`, `data1`  in  8  request bytes; each must be stable while its req is high.
- `ack0`, `ack1`  out  1  one-cycle pulse; the byte has been latched and the requester may change data or drop req.
- `tx_bps_clk`  in  1  one-cycle bit tick from the baud generator.
- `tx_count_sig`  out  1  baud generator run enable.
- `txd`  out  1  serial line, idle high.
- `busy`  out  1  high from grant until the frame completes.
- `grant_id`  out  1  requester that owns the current or most recent frame.
- `done`  out  1  one-cycle pulse when the last stop bit ends.

## Operation
- States: IDLE, WAIT_START, DATA, PARITY, STOP.
- **IDLE**
  - Sample `req0`/`req1`.
  - If exactly one is high, grant it.
  - If both are high, grant the requester that is not `last_grant`.
  - `last_grant` resets to 1, so `req0` wins the first tie.
  - On grant:
    - Latch the byte into `shreg`.
    - Pulse the matching ack.
    - Set `grant_id` and `last_grant`.
    - Set `busy` and `tx_count_sig`.
    - Go to WAIT_START.
- **WAIT_START**: `txd`=1. On a tick, `txd`←0 (start bit), `bit_cnt`←0, go to DATA.
- **DATA**
  - On each tick, `txd`←`shreg[bit_cnt]` (LSB first) and increment `bit_cnt`.
  - The tick after bit 7 is driven goes to PARITY if `PARITY_EN`, else STOP.
- **PARITY**: On entry tick, `txd`←XOR of the 8 bits, inverted if `PARITY_ODD`. The next tick goes to STOP.
- **STOP**
  - On entry tick, `txd`←1 and `stop_cnt`←0.
  - Each later tick increments `stop_cnt`.
  - When `STOP_BITS` ticks have elapsed after entry:
    - Pulse `done` and go to IDLE.
    - Clear `busy` and `tx_count_sig` in the same cycle.
- Ticks have no effect in IDLE.
- Requests are ignored while `busy`. A req still high in the cycle after its ack counts as a new request. Requesters must drop req on ack.
- Bit period is the tick spacing, so every bit, including start, lasts one full baud period.
- Frame tick count after WAIT_START:
  - 1 start tick, 8 data ticks, plus 1 parity tick if `PARITY_EN`, plus `STOP_BITS` stop ticks.
  - The final tick ends the last stop bit.

## Timing
- Reset values:
  - `txd`=1; `tx_count_sig`, `busy`, `done`, `ack0`, `ack1`, `grant_id`=0.
  - State IDLE, `last_grant`=1, `shreg`=0.
- Grant latency: req high in IDLE at edge N gives ack, `busy` and `tx_count_sig` high in cycle N+1.
- Every output is registered, and `txd` changes the cycle after the tick is sampled.
- `done` is high in the same cycle that `busy` falls.
- Back-to-back frames:
  - `tx_count_sig` is low for at least one cycle between frames, which clears the baud counter.
  - A pending request is granted at the earliest on the cycle after `done`.
- Reset mid-frame (`rst` high at any edge):
  - Next cycle, `txd`=1 and `tx_count_sig`=0.
  - No `done` pulse and no further ack.
- Simultaneous events:
  - A tick in the same cycle as grant is ignored; WAIT_START is entered after it.
  - A req asserted in the same cycle `done` pulses is seen only in IDLE, one cycle later.

## Test plan
- **Single frame.** Baud model at 16 cycles per tick. `req0`=1 with `data0`=0x55 → `ack0` one cycle after req. `txd` sequence per tick is 0,1,0,1,0,1,0,1,0,1. `done` arrives 10 ticks after the start tick, then `busy`=0.
- **Simultaneous requests after reset.** `req0` with 0xA5 and `req1` with 0x3C together → `req0` is granted first (`grant_id`=0). `req1` frame follows with `grant_id`=1, and `tx_count_sig` is low for at least 1 cycle between frames.
- **Round-robin fairness.** `req0` and `req1` held continuously for 4 frames → `grant_id` sequence is 0,1,0,1.
- **Parity and stop bits.** `PARITY_EN`=1, `PARITY_ODD`=1, `STOP_BITS`=2, byte 0x07 → parity bit 0 (three ones, odd parity). Then 2 stop ticks high, with 12 ticks total.
- **Reset mid-frame.** `rst` pulsed after data bit 3 → next cycle `txd`=1, `tx_count_sig`=0, `busy`=0, no `done`. A new `req1` afterwards starts a fresh full frame.
- **Ticks and requests during a frame.** Ticks in IDLE cause no `txd` change. `req1` raised during a `req0` frame gets no ack until the cycle after `done`+1.
